// File: rtl/gpmc_master.sv
// gpmc_master: host-side initiator for the multiplexed GPMC address/data bus.
// Turns a stb/ack request into CS/ALE/WE/OE bus cycles clocked by a sys_clk/2 gpmc_clk.

module gpmc_master #(
  parameter int ADDR_CYC  = 1,
  parameter int WRITE_CYC = 2,
  parameter int READ_CYC  = 6,
  parameter int TURN_CYC  = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        req_stb,
  input  logic        req_we,
  input  logic [25:0] req_adr,
  input  logic [15:0] req_dat_w,
  output logic        req_ack,
  output logic [15:0] req_dat_r,
  output logic        busy,
  output logic        gpmc_clk,
  output logic [9:0]  gpmc_a,
  inout  wire  [15:0] gpmc_d,
  output logic        gpmc_cs_n,
  output logic        gpmc_ale_n,
  output logic        gpmc_we_n,
  output logic        gpmc_oe_n
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_TURN  = 3'd4
  } state_t;

  localparam logic [3:0] ADDR_LD  = 4'(ADDR_CYC - 1);
  localparam logic [3:0] WRITE_LD = 4'(WRITE_CYC - 1);
  localparam logic [3:0] READ_LD  = 4'(READ_CYC - 1);
  localparam logic [3:0] TURN_LD  = 4'(TURN_CYC - 1);

  state_t      r_state, w_state;
  logic [3:0]  r_cnt, w_cnt;
  logic        r_gclk;
  logic        r_we, w_we;
  logic [15:0] r_dat_w, w_dat_w;
  logic [9:0]  r_a, w_a;
  logic [15:0] r_d_out, w_d_out;
  logic        r_d_oe, w_d_oe;
  logic        r_cs_n, w_cs_n;
  logic        r_ale_n, w_ale_n;
  logic        r_we_n, w_we_n;
  logic        r_oe_n, w_oe_n;
  logic        r_ack, w_ack;
  logic [15:0] r_dat_r, w_dat_r;
  logic        r_busy, w_busy;
  logic        w_last;
  logic        w_start;
  logic        w_to_turn;

  assign gpmc_d     = r_d_oe ? r_d_out : 16'hzzzz;
  assign gpmc_clk   = r_gclk;
  assign gpmc_a     = r_a;
  assign gpmc_cs_n  = r_cs_n;
  assign gpmc_ale_n = r_ale_n;
  assign gpmc_we_n  = r_we_n;
  assign gpmc_oe_n  = r_oe_n;
  assign req_ack    = r_ack;
  assign req_dat_r  = r_dat_r;
  assign busy       = r_busy;

  // Bus clock divider; a cycle with gpmc_clk high is a tick
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      r_gclk <= 1'b0;
    end else begin
      r_gclk <= ~r_gclk;
    end
  end

  // Next-state and next-output logic; everything moves only on the edge closing a tick
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_we      = r_we;
    w_dat_w   = r_dat_w;
    w_a       = r_a;
    w_d_out   = r_d_out;
    w_d_oe    = r_d_oe;
    w_cs_n    = r_cs_n;
    w_ale_n   = r_ale_n;
    w_we_n    = r_we_n;
    w_oe_n    = r_oe_n;
    w_ack     = 1'b0;
    w_dat_r   = r_dat_r;
    w_busy    = r_busy;
    w_start   = 1'b0;
    w_to_turn = 1'b0;
    w_last    = (r_cnt == 4'd0);

    if (r_gclk) begin
      case (r_state)
        S_IDLE: begin
          if (req_stb) begin
            w_start = 1'b1;
          end else begin
            w_state = S_IDLE;
          end
        end
        S_ADDR: begin
          if (w_last) begin
            w_ale_n = 1'b1;
            if (r_we) begin
              w_state = S_WRITE;
              w_cnt   = WRITE_LD;
              w_we_n  = 1'b0;
              w_d_out = r_dat_w;
              w_d_oe  = 1'b1;
            end else begin
              // release the bus at once so the slave can drive during OE
              w_state = S_READ;
              w_cnt   = READ_LD;
              w_oe_n  = 1'b0;
              w_d_oe  = 1'b0;
            end
          end else begin
            w_cnt = r_cnt - 4'd1;
          end
        end
        S_WRITE: begin
          if (w_last) begin
            w_to_turn = 1'b1;
          end else begin
            w_cnt = r_cnt - 4'd1;
          end
        end
        S_READ: begin
          if (w_last) begin
            w_to_turn = 1'b1;
            w_dat_r   = gpmc_d;
          end else begin
            w_cnt = r_cnt - 4'd1;
          end
        end
        S_TURN: begin
          if (w_last) begin
            if (req_stb) begin
              w_start = 1'b1;
            end else begin
              w_state = S_IDLE;
              w_busy  = 1'b0;
            end
          end else begin
            w_cnt = r_cnt - 4'd1;
          end
        end
        default: begin
          w_state = S_IDLE;
          w_cnt   = 4'd0;
          w_cs_n  = 1'b1;
          w_ale_n = 1'b1;
          w_we_n  = 1'b1;
          w_oe_n  = 1'b1;
          w_d_oe  = 1'b0;
          w_busy  = 1'b0;
        end
      endcase
    end else begin
      w_state = r_state;
    end

    if (w_start) begin
      w_state = S_ADDR;
      w_cnt   = ADDR_LD;
      w_we    = req_we;
      w_dat_w = req_dat_w;
      w_a     = req_adr[25:16];
      w_d_out = req_adr[15:0];
      w_d_oe  = 1'b1;
      w_cs_n  = 1'b0;
      w_ale_n = 1'b0;
      w_busy  = 1'b1;
    end else if (w_to_turn) begin
      w_state = S_TURN;
      w_cnt   = TURN_LD;
      w_cs_n  = 1'b1;
      w_we_n  = 1'b1;
      w_oe_n  = 1'b1;
      w_d_oe  = 1'b0;
      w_ack   = 1'b1;
    end else begin
      w_ack = 1'b0;
    end
  end

  // State and registered bus/request outputs
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_dat_w <= 16'h0000;
      r_a     <= 10'h000;
      r_d_out <= 16'h0000;
      r_d_oe  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_ale_n <= 1'b1;
      r_we_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_ack   <= 1'b0;
      r_dat_r <= 16'h0000;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_we    <= w_we;
      r_dat_w <= w_dat_w;
      r_a     <= w_a;
      r_d_out <= w_d_out;
      r_d_oe  <= w_d_oe;
      r_cs_n  <= w_cs_n;
      r_ale_n <= w_ale_n;
      r_we_n  <= w_we_n;
      r_oe_n  <= w_oe_n;
      r_ack   <= w_ack;
      r_dat_r <= w_dat_r;
      r_busy  <= w_busy;
    end
  end

endmodule

// File: tb/tb_gpmc_master.sv
// Directed self-checking bench for gpmc_master: default-timing instance plus an all-ones timing instance.
// Bus nets are pulled up, so an undriven gpmc_d reads as 16'hFFFF.

module tb_gpmc_master;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        req_stb = 1'b0, req_we = 1'b0;
  logic [25:0] req_adr = 26'h0;
  logic [15:0] req_dat_w = 16'h0;
  logic        req_ack, busy, gpmc_clk, cs_n, ale_n, we_n, oe_n;
  logic [15:0] req_dat_r;
  logic [9:0]  gpmc_a;
  tri1  [15:0] gpmc_d;
  logic [15:0] slave_val = 16'h0;

  logic        m_req_stb = 1'b0, m_req_we = 1'b0;
  logic [25:0] m_req_adr = 26'h0;
  logic [15:0] m_req_dat_w = 16'h0;
  logic        m_req_ack, m_busy, m_gpmc_clk, m_cs_n, m_ale_n, m_we_n, m_oe_n;
  logic [15:0] m_req_dat_r;
  logic [9:0]  m_gpmc_a;
  tri1  [15:0] m_gpmc_d;
  logic [15:0] m_slave_val = 16'h0;

  // slave models drive read data only in the data phase of a read
  assign gpmc_d   = (!cs_n && !oe_n && ale_n) ? slave_val : 16'hzzzz;
  assign m_gpmc_d = (!m_cs_n && !m_oe_n && m_ale_n) ? m_slave_val : 16'hzzzz;

  gpmc_master u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req_stb(req_stb), .req_we(req_we),
    .req_adr(req_adr), .req_dat_w(req_dat_w), .req_ack(req_ack), .req_dat_r(req_dat_r),
    .busy(busy), .gpmc_clk(gpmc_clk), .gpmc_a(gpmc_a), .gpmc_d(gpmc_d),
    .gpmc_cs_n(cs_n), .gpmc_ale_n(ale_n), .gpmc_we_n(we_n), .gpmc_oe_n(oe_n)
  );

  gpmc_master #(.ADDR_CYC(1), .WRITE_CYC(1), .READ_CYC(1), .TURN_CYC(1)) u_min (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req_stb(m_req_stb), .req_we(m_req_we),
    .req_adr(m_req_adr), .req_dat_w(m_req_dat_w), .req_ack(m_req_ack), .req_dat_r(m_req_dat_r),
    .busy(m_busy), .gpmc_clk(m_gpmc_clk), .gpmc_a(m_gpmc_a), .gpmc_d(m_gpmc_d),
    .gpmc_cs_n(m_cs_n), .gpmc_ale_n(m_ale_n), .gpmc_we_n(m_we_n), .gpmc_oe_n(m_oe_n)
  );

  int checks = 0;
  int errors = 0;

  logic        t_cs[64], t_ale[64], t_we[64], t_oe[64], t_clk[64], t_ack[64], t_busy[64];
  logic [9:0]  t_a[64];
  logic [15:0] t_d[64], t_dr[64];

  logic        nxt_valid = 1'b0;
  logic        nxt_we = 1'b0;
  logic [25:0] nxt_adr = 26'h0;
  logic [15:0] nxt_dat = 16'h0;
  int          scramble_at = -1;
  int          rst_at = -1;

  // Sample one instance at each falling sys_clk edge and play the requester role
  task automatic record(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      if (sel == 0) begin
        t_cs[i] = cs_n; t_ale[i] = ale_n; t_we[i] = we_n; t_oe[i] = oe_n;
        t_clk[i] = gpmc_clk; t_ack[i] = req_ack; t_busy[i] = busy;
        t_a[i] = gpmc_a; t_d[i] = gpmc_d; t_dr[i] = req_dat_r;
      end else begin
        t_cs[i] = m_cs_n; t_ale[i] = m_ale_n; t_we[i] = m_we_n; t_oe[i] = m_oe_n;
        t_clk[i] = m_gpmc_clk; t_ack[i] = m_req_ack; t_busy[i] = m_busy;
        t_a[i] = m_gpmc_a; t_d[i] = m_gpmc_d; t_dr[i] = m_req_dat_r;
      end
      if (sel == 0 && i == scramble_at) begin
        req_adr = 26'h3FFFFFF; req_dat_w = 16'h0000; req_we = ~req_we;
      end
      if (i == rst_at) begin
        sys_rst = 1'b0; req_stb = 1'b0;
      end else begin
        sys_rst = 1'b1;
      end
      if (t_ack[i] === 1'b1) begin
        if (nxt_valid) begin
          nxt_valid = 1'b0;
          req_we = nxt_we; req_adr = nxt_adr;
        end else if (sel == 0) begin
          req_stb = 1'b0;
        end else begin
          m_req_stb = 1'b0;
        end
      end
    end
  endtask

  // Wait (bounded) for a falling edge at which gpmc_clk shows level v
  task automatic align(input logic v);
    for (int k = 0; k < 4; k++) begin
      if (gpmc_clk === v) break;
      @(negedge sys_clk);
    end
  endtask

  function automatic int find_ale(input int n);
    for (int i = 0; i < n; i++) if (t_ale[i] === 1'b0) return i;
    return -1;
  endfunction

  function automatic int count_acks(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (t_ack[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_misaligned(input int n);
    int c = 0;
    for (int i = 1; i < n; i++) begin
      if ((t_cs[i] !== t_cs[i-1] || t_ale[i] !== t_ale[i-1] || t_we[i] !== t_we[i-1] ||
           t_oe[i] !== t_oe[i-1] || t_d[i] !== t_d[i-1]) &&
          !(t_clk[i-1] === 1'b1 && t_clk[i] === 1'b0)) c++;
    end
    return c;
  endfunction

  task automatic test_reset();
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if ({gpmc_clk, cs_n, ale_n, we_n, oe_n} !== 5'b01111) begin
      errors++; $display("FAIL reset_strobes: got clk/cs/ale/we/oe=%b expected 01111", {gpmc_clk, cs_n, ale_n, we_n, oe_n});
    end
    checks++;
    if (gpmc_a !== 10'h000 || gpmc_d !== 16'hFFFF) begin
      errors++; $display("FAIL reset_bus: got a=%h d=%h expected a=000 d=ffff(Z)", gpmc_a, gpmc_d);
    end
    checks++;
    if ({req_ack, busy, req_dat_r} !== 18'h0) begin
      errors++; $display("FAIL reset_req: got ack=%b busy=%b dat_r=%h expected 0 0 0000", req_ack, busy, req_dat_r);
    end
    checks++;
    if ({m_gpmc_clk, m_cs_n, m_busy} !== 3'b010) begin
      errors++; $display("FAIL reset_min: got clk/cs/busy=%b expected 010", {m_gpmc_clk, m_cs_n, m_busy});
    end
    sys_rst = 1'b1;
    @(negedge sys_clk);
    checks++;
    if (gpmc_clk !== 1'b1) begin
      errors++; $display("FAIL gclk_first: got %b expected 1", gpmc_clk);
    end
    @(negedge sys_clk);
    checks++;
    if (gpmc_clk !== 1'b0) begin
      errors++; $display("FAIL gclk_second: got %b expected 0", gpmc_clk);
    end
  endtask

  task automatic test_write();
    int i0;
    logic [4:0] exp;
    align(1'b1);
    req_we = 1'b1; req_adr = 26'h0123456; req_dat_w = 16'hBEEF; req_stb = 1'b1;
    scramble_at = 0;
    record(0, 16);
    scramble_at = -1;
    i0 = find_ale(16);
    checks++;
    if (i0 !== 0) begin
      errors++; $display("FAIL write_accept: got ale at %0d expected 0", i0);
    end
    for (int i = 0; i < 10; i++) begin
      exp = {(i < 2) ? 1'b0 : 1'b1, (i >= 2 && i <= 5) ? 1'b0 : 1'b1, (i <= 5) ? 1'b0 : 1'b1, 1'b1, (i == 6) ? 1'b1 : 1'b0};
      checks++;
      if ({t_ale[i], t_we[i], t_cs[i], t_oe[i], t_ack[i]} !== exp) begin
        errors++; $display("FAIL write_strobes[%0d]: got ale/we/cs/oe/ack=%b expected %b", i, {t_ale[i], t_we[i], t_cs[i], t_oe[i], t_ack[i]}, exp);
      end
    end
    checks++;
    if (t_a[0] !== 10'h012 || t_d[0] !== 16'h3456) begin
      errors++; $display("FAIL write_addr: got a=%h d=%h expected 012 3456", t_a[0], t_d[0]);
    end
    checks++;
    if (t_d[2] !== 16'hBEEF || t_d[5] !== 16'hBEEF) begin
      errors++; $display("FAIL write_data: got %h/%h expected beef/beef", t_d[2], t_d[5]);
    end
    checks++;
    if (t_d[6] !== 16'hFFFF || t_a[7] !== 10'h012) begin
      errors++; $display("FAIL write_turn: got d=%h a=%h expected ffff(Z) 012", t_d[6], t_a[7]);
    end
    checks++;
    if ({t_busy[0], t_busy[7], t_busy[8]} !== 3'b110) begin
      errors++; $display("FAIL write_busy: got %b expected 110", {t_busy[0], t_busy[7], t_busy[8]});
    end
  endtask

  task automatic test_read();
    logic [3:0] exp;
    align(1'b1);
    slave_val = 16'hCAFE;
    req_we = 1'b0; req_adr = 26'h2ABCDE; req_stb = 1'b1;
    record(0, 20);
    for (int i = 0; i < 18; i++) begin
      exp = {(i < 2) ? 1'b0 : 1'b1, (i >= 2 && i <= 13) ? 1'b0 : 1'b1, (i <= 13) ? 1'b0 : 1'b1, (i == 14) ? 1'b1 : 1'b0};
      checks++;
      if ({t_ale[i], t_oe[i], t_cs[i], t_ack[i]} !== exp || t_we[i] !== 1'b1) begin
        errors++; $display("FAIL read_strobes[%0d]: got ale/oe/cs/ack=%b we=%b expected %b we=1", i, {t_ale[i], t_oe[i], t_cs[i], t_ack[i]}, t_we[i], exp);
      end
    end
    checks++;
    if (t_a[0] !== 10'h02A || t_d[0] !== 16'hBCDE) begin
      errors++; $display("FAIL read_addr: got a=%h d=%h expected 02a bcde", t_a[0], t_d[0]);
    end
    checks++;
    if (t_d[2] !== 16'hCAFE || t_d[13] !== 16'hCAFE) begin
      errors++; $display("FAIL read_contention: got %h/%h expected cafe/cafe", t_d[2], t_d[13]);
    end
    checks++;
    if (t_dr[13] !== 16'h0000 || t_dr[14] !== 16'hCAFE || t_dr[17] !== 16'hCAFE) begin
      errors++; $display("FAIL read_data: got %h/%h/%h expected 0000/cafe/cafe", t_dr[13], t_dr[14], t_dr[17]);
    end
    checks++;
    if (t_d[14] !== 16'hFFFF) begin
      errors++; $display("FAIL read_release: got %h expected ffff(Z)", t_d[14]);
    end
  endtask

  task automatic test_back_to_back();
    int acks;
    align(1'b1);
    slave_val = 16'h5A5A;
    req_we = 1'b1; req_adr = 26'h0000001; req_dat_w = 16'hAAAA; req_stb = 1'b1;
    nxt_valid = 1'b1; nxt_we = 1'b0; nxt_adr = 26'h0000002;
    record(0, 28);
    acks = count_acks(28);
    checks++;
    if (acks !== 2 || t_ack[6] !== 1'b1 || t_ack[22] !== 1'b1) begin
      errors++; $display("FAIL b2b_acks: got count=%0d ack6=%b ack22=%b expected 2 1 1", acks, t_ack[6], t_ack[22]);
    end
    checks++;
    if ({t_ale[7], t_ale[8], t_ale[9], t_ale[10]} !== 4'b1001) begin
      errors++; $display("FAIL b2b_ale_gap: got ale7..10=%b expected 1001", {t_ale[7], t_ale[8], t_ale[9], t_ale[10]});
    end
    checks++;
    if (t_d[0] !== 16'h0001 || t_d[2] !== 16'hAAAA || t_d[8] !== 16'h0002 || t_a[8] !== 10'h000) begin
      errors++; $display("FAIL b2b_bus: got %h %h %h a=%h expected 0001 aaaa 0002 000", t_d[0], t_d[2], t_d[8], t_a[8]);
    end
    checks++;
    if ({t_busy[6], t_busy[7], t_busy[8], t_oe[10], t_oe[21], t_oe[22]} !== 6'b111001) begin
      errors++; $display("FAIL b2b_read_phase: got %b expected 111001", {t_busy[6], t_busy[7], t_busy[8], t_oe[10], t_oe[21], t_oe[22]});
    end
    checks++;
    if (t_dr[22] !== 16'h5A5A) begin
      errors++; $display("FAIL b2b_read_data: got %h expected 5a5a", t_dr[22]);
    end
  endtask

  task automatic test_alignment();
    int i0, bad;
    align(1'b0);
    req_we = 1'b1; req_adr = 26'h3FF0F0F; req_dat_w = 16'h1357; req_stb = 1'b1;
    record(0, 16);
    i0 = find_ale(16);
    checks++;
    if (i0 !== 1) begin
      errors++; $display("FAIL align_accept: got ale at %0d expected 1", i0);
    end
    bad = count_misaligned(16);
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL align_edges: got %0d off-edge transitions expected 0", bad);
    end
    checks++;
    if (t_ack[7] !== 1'b1 || t_a[1] !== 10'h3FF || t_d[3] !== 16'h1357) begin
      errors++; $display("FAIL align_txn: got ack7=%b a=%h d=%h expected 1 3ff 1357", t_ack[7], t_a[1], t_d[3]);
    end
  endtask

  task automatic test_reset_mid();
    int acks;
    align(1'b1);
    req_we = 1'b1; req_adr = 26'h0000ABC; req_dat_w = 16'h2468; req_stb = 1'b1;
    rst_at = 4;
    record(0, 14);
    rst_at = -1;
    checks++;
    if (t_we[4] !== 1'b0) begin
      errors++; $display("FAIL rstmid_in_write: got we_n=%b expected 0", t_we[4]);
    end
    checks++;
    if ({t_clk[5], t_cs[5], t_ale[5], t_we[5], t_oe[5], t_ack[5], t_busy[5]} !== 7'b0111100) begin
      errors++; $display("FAIL rstmid_release: got clk/cs/ale/we/oe/ack/busy=%b expected 0111100",
                         {t_clk[5], t_cs[5], t_ale[5], t_we[5], t_oe[5], t_ack[5], t_busy[5]});
    end
    checks++;
    if (t_d[5] !== 16'hFFFF) begin
      errors++; $display("FAIL rstmid_bus_z: got %h expected ffff(Z)", t_d[5]);
    end
    acks = count_acks(14);
    checks++;
    if (acks !== 0) begin
      errors++; $display("FAIL rstmid_no_ack: got %0d acks expected 0", acks);
    end
    align(1'b1);
    slave_val = 16'h0F1E;
    req_we = 1'b0; req_adr = 26'h0000777; req_stb = 1'b1;
    record(0, 18);
    checks++;
    if (t_ack[14] !== 1'b1 || t_dr[14] !== 16'h0F1E || count_acks(18) !== 1) begin
      errors++; $display("FAIL rstmid_reread: got ack14=%b dat=%h acks=%0d expected 1 0f1e 1", t_ack[14], t_dr[14], count_acks(18));
    end
  endtask

  task automatic test_min_timing();
    int i0;
    align(1'b1);
    m_req_we = 1'b1; m_req_adr = 26'h1555555; m_req_dat_w = 16'h3C3C; m_req_stb = 1'b1;
    record(1, 10);
    i0 = find_ale(10);
    checks++;
    if (i0 !== 0 || t_a[0] !== 10'h155 || t_d[0] !== 16'h5555) begin
      errors++; $display("FAIL min_write_addr: got i0=%0d a=%h d=%h expected 0 155 5555", i0, t_a[0], t_d[0]);
    end
    checks++;
    if ({t_we[1], t_we[2], t_we[3], t_we[4], t_ack[3], t_ack[4], t_ack[5]} !== 7'b1001010) begin
      errors++; $display("FAIL min_write_timing: got we1..4/ack3..5=%b expected 1001010",
                         {t_we[1], t_we[2], t_we[3], t_we[4], t_ack[3], t_ack[4], t_ack[5]});
    end
    checks++;
    if (t_d[2] !== 16'h3C3C) begin
      errors++; $display("FAIL min_write_data: got %h expected 3c3c", t_d[2]);
    end
    align(1'b1);
    m_slave_val = 16'hA5C3;
    m_req_we = 1'b0; m_req_adr = 26'h0000010; m_req_stb = 1'b1;
    record(1, 10);
    checks++;
    if ({t_oe[1], t_oe[2], t_oe[3], t_oe[4], t_ack[3], t_ack[4], t_ack[5]} !== 7'b1001010) begin
      errors++; $display("FAIL min_read_timing: got oe1..4/ack3..5=%b expected 1001010",
                         {t_oe[1], t_oe[2], t_oe[3], t_oe[4], t_ack[3], t_ack[4], t_ack[5]});
    end
    checks++;
    if (t_dr[4] !== 16'hA5C3) begin
      errors++; $display("FAIL min_read_data: got %h expected a5c3", t_dr[4]);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_alignment();
    test_reset_mid();
    test_min_timing();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
